data_chk: RTL and testbench
===========================

Name: data_chk

Overview:
- AXI-Stream sink that sits directly downstream of the data_gen stage and checks its output.
- Accepts a transfer of `size` beats, checks each beat against the same incrementing-byte pattern (seed 0x80, +1 per byte lane, +WIDTH/8 per beat, mod 256), and checks tlast placement.
- Reports pass/fail and error statistics through an ap_start/ap_done/ap_idle/ap_ready control handshake.
- Used in the AXI-MM loopback testbenches as the self-checking endpoint.

Parameters:
- WIDTH, 32, tdata width in bits; a multiple of 8, from 8 to 512.
- SEED, 8'h80, byte value expected in lane 0 of beat 0.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- size  in  32  beats expected; sampled on the ap_start acceptance cycle.
- stall  in  1  backpressure injection; while 1, tready is held 0.
- ap_start  in  1  request to start a check run.
- ap_ready  out  1  ap_start accepted this cycle (combinational).
- ap_idle  out  1  block is in IDLE.
- ap_done  out  1  one-cycle pulse when the run completes (registered).
- tdata  in  WIDTH  stream data.
- tvalid  in  1  stream valid.
- tlast  in  1  stream last.
- tready  out  1  stream ready.
- beat_count  out  32  beats accepted in the last or current run.
- err_count  out  32  accepted beats with at least one byte-lane mismatch.
- first_err_beat  out  32  index of the first mismatching beat; 32'hFFFFFFFF if none.
- tlast_err  out  1  tlast was early, or missing on the final beat.
- pass  out  1  err_count==0 and tlast_err==0; valid from the ap_done pulse onward.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - state=IDLE, ap_idle=1, ap_ready=0, ap_done=0, tready=0.
  - beat_count=0, err_count=0, first_err_beat=FFFFFFFF, tlast_err=0, pass=0.
  - Any in-flight transfer is abandoned.
- State machine: IDLE, READY, RUN, DONE.
- IDLE:
  - tready=0.
  - If ap_start: ap_ready=1 (same cycle), latch size, clear all statistics, expected seed=SEED, go to READY.
- READY:
  - One cycle, tready=0.
  - Go to RUN if the latched size is nonzero; otherwise go to DONE.
- RUN:
  - tready=!stall.
  - A beat is accepted when tvalid && tready.
  - On accept:
    - Lane i is expected to be (seed+i) mod 256.
    - On any lane mismatch, err_count+1; if first_err_beat==FFFFFFFF, first_err_beat=beat_count (pre-increment value).
    - is_last = (beat_count==size-1).
    - If tlast != is_last, tlast_err=1.
    - beat_count+1; seed+=WIDTH/8 mod 256.
    - If is_last or tlast, go to DONE, so an early tlast terminates the run.
  - tvalid without tready: no state change.
  - Data and tlast are checked only on accepted beats.
- DONE:
  - One cycle; ap_done=1 is registered, so it is visible the cycle after the final beat.
  - pass updates on that same cycle; go to IDLE.
- Statistics and pass hold their values until the next ap_start acceptance.
- ap_start in READY, RUN or DONE is ignored; ap_ready stays 0.
- size==0: no beats accepted, pass=1, ap_done arrives 2 cycles after ap_ready.
- Latency: ap_ready -> first possible beat accept = 2 cycles; last accept -> ap_done = 1 cycle.
- Counters wrap modulo 2^32; err_count saturates at FFFFFFFF.
- Seed arithmetic is 8-bit and wraps (0xFC+4 -> 0x00).

Decomposition:
- Shared package data_gen_pkg holds:
  - State encoding (IDLE/READY/RUN/DONE, 2 bits), shared with data_gen.
  - Default SEED constant.
  - Function expected_beat(seed, WIDTH) that returns the WIDTH-bit pattern; the bench and data_gen also use it.
- One sub-module, data_chk_lane_cmp:
  - Combinational per-lane comparator taking tdata and seed.
  - Produces a mismatch vector of WIDTH/8 bits, OR-reduced in the parent.

Test Plan:
- WIDTH=32, size=4, clean stream, tlast on beat 3 -> bytes 80..8F accepted; beat_count=4, err_count=0, first_err_beat=FFFFFFFF, pass=1, ap_done 1 cycle after beat 3.
- size=4, beat 2 byte 1 forced to 0x00 -> err_count=1, first_err_beat=2, tlast_err=0, pass=0.
- size=4, tlast on beat 1 -> run ends after beat 1: beat_count=2, tlast_err=1, pass=0, tready=0 afterwards. Same size with tlast never asserted -> tlast_err=1, beat_count=4.
- size=40, stall toggled every 3 cycles, source holds tvalid -> beat_count=40, no duplicates or drops, seed wraps FC->00 at beat 31, pass=1.
- size=0 -> ap_ready, ap_done 2 cycles later, tready never 1, pass=1, beat_count=0.
- reset_n pulled low at beat 5 of size=10, then a fresh run with size=2 -> outputs at reset values during reset; second run gives beat_count=2, pass=1.

Source files
------------

// File: rtl/data_gen_pkg.sv
// Shared definitions for the data_gen / data_chk stream pair: FSM encoding,
// default pattern seed and the reference incrementing-byte beat pattern.
package data_gen_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReady = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [7:0] DefaultSeed = 8'h80;
  localparam int unsigned MaxWidth = 512;

  // Lane i of the returned beat is (seed + i) mod 256; lanes beyond width/8 are zero.
  function automatic logic [MaxWidth-1:0] expected_beat(input logic [7:0] seed,
                                                        input int unsigned width);
    logic [MaxWidth-1:0] beat;
    beat = '0;
    for (int unsigned i = 0; i < MaxWidth / 8; i++) begin
      if (i < width / 8) begin
        beat[8*i +: 8] = seed + 8'(i);
      end
    end
    return beat;
  endfunction

endpackage

// File: rtl/data_chk_lane_cmp.sv
// Per-lane comparator: flags every byte lane of tdata that differs from the
// incrementing pattern starting at seed.
module data_chk_lane_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   tdata,
  input  logic [7:0]         seed,
  output logic [WIDTH/8-1:0] mismatch
);

  localparam int unsigned Lanes = WIDTH / 8;

  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    logic [7:0] exp_byte;
    assign exp_byte    = seed + 8'(i);
    assign mismatch[i] = (tdata[8*i +: 8] != exp_byte);
  end

endmodule

// File: rtl/data_chk.sv
// AXI-Stream sink that checks an incrementing-byte transfer of a given length
// and reports statistics through an ap_start/ap_done control handshake.
module data_chk
  import data_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter logic [7:0]  SEED  = DefaultSeed
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      size,
  input  logic             stall,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_idle,
  output logic             ap_done,
  input  logic [WIDTH-1:0] tdata,
  input  logic             tvalid,
  input  logic             tlast,
  output logic             tready,
  output logic [31:0]      beat_count,
  output logic [31:0]      err_count,
  output logic [31:0]      first_err_beat,
  output logic             tlast_err,
  output logic             pass
);

  localparam int unsigned Lanes    = WIDTH / 8;
  localparam logic [7:0]  SeedStep = 8'(Lanes);
  localparam logic [31:0] NoErr    = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] size_q, size_d;
  logic [7:0]  seed_q, seed_d;
  logic [31:0] beat_count_q, beat_count_d;
  logic [31:0] err_count_q, err_count_d;
  logic [31:0] first_err_q, first_err_d;
  logic        tlast_err_q, tlast_err_d;
  logic        pass_q, pass_d;
  logic        ap_done_q, ap_done_d;

  logic [Lanes-1:0] mismatch;
  logic             accept;
  logic             is_last;

  data_chk_lane_cmp #(
    .WIDTH (WIDTH)
  ) u_lane_cmp (
    .tdata    (tdata),
    .seed     (seed_q),
    .mismatch (mismatch)
  );

  assign is_last = (beat_count_q == size_q - 32'd1);
  assign accept  = tvalid && tready;

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    seed_d       = seed_q;
    beat_count_d = beat_count_q;
    err_count_d  = err_count_q;
    first_err_d  = first_err_q;
    tlast_err_d  = tlast_err_q;
    pass_d       = pass_q;
    ap_ready     = 1'b0;
    tready       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          ap_ready     = 1'b1;
          size_d       = size;
          seed_d       = SEED;
          beat_count_d = '0;
          err_count_d  = '0;
          first_err_d  = NoErr;
          tlast_err_d  = 1'b0;
          pass_d       = 1'b0;
          state_d      = StReady;
        end
      end
      StReady: begin
        state_d = (size_q != 32'd0) ? StRun : StDone;
      end
      StRun: begin
        tready = !stall;
        if (accept) begin
          if (|mismatch) begin
            if (err_count_q != NoErr) begin
              err_count_d = err_count_q + 32'd1;
            end
            if (first_err_q == NoErr) begin
              first_err_d = beat_count_q;
            end
          end
          if (tlast != is_last) begin
            tlast_err_d = 1'b1;
          end
          beat_count_d = beat_count_q + 32'd1;
          seed_d       = seed_q + SeedStep;
          // An early tlast ends the run as well as the expected final beat.
          if (is_last || tlast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // DONE is only ever entered from READY or RUN, so this fires once per run.
    if (state_d == StDone) begin
      pass_d = (err_count_d == 32'd0) && !tlast_err_d;
    end
  end

  assign ap_done_d = (state_d == StDone);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      size_q       <= '0;
      seed_q       <= SEED;
      beat_count_q <= '0;
      err_count_q  <= '0;
      first_err_q  <= NoErr;
      tlast_err_q  <= 1'b0;
      pass_q       <= 1'b0;
      ap_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      seed_q       <= seed_d;
      beat_count_q <= beat_count_d;
      err_count_q  <= err_count_d;
      first_err_q  <= first_err_d;
      tlast_err_q  <= tlast_err_d;
      pass_q       <= pass_d;
      ap_done_q    <= ap_done_d;
    end
  end

  assign ap_idle        = (state_q == StIdle);
  assign ap_done        = ap_done_q;
  assign beat_count     = beat_count_q;
  assign err_count      = err_count_q;
  assign first_err_beat = first_err_q;
  assign tlast_err      = tlast_err_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_data_chk.sv
// Directed bench for data_chk: stimulus pushes expected run results into a queue,
// a monitor pops and compares them on every ap_done pulse.
module tb_data_chk;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] size = '0;
  logic        stall = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_ready, ap_idle, ap_done;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [31:0] beat_count, err_count, first_err_beat;
  logic        tlast_err, pass;

  typedef struct {
    logic [31:0] beats;
    logic [31:0] errs;
    logic [31:0] first;
    logic        tl_err;
    logic        ps;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  data_chk #(
    .WIDTH (32),
    .SEED  (8'h80)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .size           (size),
    .stall          (stall),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_idle        (ap_idle),
    .ap_done        (ap_done),
    .tdata          (tdata),
    .tvalid         (tvalid),
    .tlast          (tlast),
    .tready         (tready),
    .beat_count     (beat_count),
    .err_count      (err_count),
    .first_err_beat (first_err_beat),
    .tlast_err      (tlast_err),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat b, lane i carries 0x80 + 4*b + i (mod 256).
  function automatic logic [31:0] beat_word(input int b);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = 8'((128 + 4 * b + i) % 256);
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (reset_n && ap_done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got ap_done=1 expected no pending run");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_beat_count", beat_count, e.beats);
        check("done_err_count", err_count, e.errs);
        check("done_first_err_beat", first_err_beat, e.first);
        check("done_tlast_err", 32'(tlast_err), 32'(e.tl_err));
        check("done_pass", 32'(pass), 32'(e.ps));
      end
    end
  end

  task automatic push_exp(input logic [31:0] beats, input logic [31:0] errs,
                          input logic [31:0] first, input logic tl, input logic ps);
    exp_t e;
    e.beats  = beats;
    e.errs   = errs;
    e.first  = first;
    e.tl_err = tl;
    e.ps     = ps;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ap_idle"}, 32'(ap_idle), 32'd1);
    check({tag, "_ap_ready"}, 32'(ap_ready), 32'd0);
    check({tag, "_ap_done"}, 32'(ap_done), 32'd0);
    check({tag, "_tready"}, 32'(tready), 32'd0);
    check({tag, "_beat_count"}, beat_count, 32'd0);
    check({tag, "_err_count"}, err_count, 32'd0);
    check({tag, "_first_err"}, first_err_beat, 32'hFFFF_FFFF);
    check({tag, "_tlast_err"}, 32'(tlast_err), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
  endtask

  // Leaves the DUT in READY with ap_start low; the first beat can be accepted
  // on the edge after the next falling edge.
  task automatic start_run(input logic [31:0] sz);
    @(negedge clk);
    check("idle_before_start", 32'(ap_idle), 32'd1);
    size     = sz;
    ap_start = 1'b1;
    #1;
    check("ap_ready_on_start", 32'(ap_ready), 32'd1);
    @(negedge clk);
    size = 32'hDEAD_BEEF;
    #1;
    check("ap_ready_ignored_in_ready", 32'(ap_ready), 32'd0);
    check("tready_in_ready", 32'(tready), 32'd0);
    ap_start = 1'b0;
  endtask

  task automatic send(input int nbeats, input int tlast_beat, input int bad_beat,
                      input bit stall_tog, input int reset_at, output int first_cyc);
    int b = 0;
    int cyc = 0;
    first_cyc = -1;
    while (b < nbeats) begin
      @(negedge clk);
      cyc++;
      stall = stall_tog ? (((cyc / 3) % 2) == 1) : 1'b0;
      if (reset_at >= 0 && b == reset_at) begin
        reset_n = 1'b0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        stall   = 1'b0;
        break;
      end
      tdata = beat_word(b);
      if (b == bad_beat) tdata[15:8] = 8'h00;
      tvalid = 1'b1;
      tlast  = (b == tlast_beat);
      #1;
      if (tready) begin
        if (b == 0) first_cyc = cyc;
        b++;
      end
      if (cyc > 1000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got %0d beats expected %0d", b, nbeats);
        break;
      end
    end
  endtask

  task automatic end_run(input string tag);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    stall  = 1'b0;
    #1;
    check({tag, "_done_latency"}, 32'(ap_done), 32'd1);
    check({tag, "_tready_done"}, 32'(tready), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(ap_done), 32'd0);
    check({tag, "_back_idle"}, 32'(ap_idle), 32'd1);
  endtask

  initial begin
    int fc;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Clean 4-beat run.
    start_run(32'd4);
    push_exp(32'd4, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send(4, 3, -1, 1'b0, -1, fc);
    check("ready_to_first_accept", 32'(fc), 32'd1);
    end_run("clean");
    check("clean_pass_holds", 32'(pass), 32'd1);

    // Corrupt byte 1 of beat 2.
    start_run(32'd4);
    push_exp(32'd4, 32'd1, 32'd2, 1'b0, 1'b0);
    send(4, 3, 2, 1'b0, -1, fc);
    end_run("corrupt");

    // Early tlast on beat 1; further valid beats must not be taken.
    start_run(32'd4);
    push_exp(32'd2, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(2, 1, -1, 1'b0, -1, fc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tdata = beat_word(2);
      tlast = 1'b0;
      #1;
      check("early_tlast_tready_low", 32'(tready), 32'd0);
    end
    tvalid = 1'b0;

    // tlast never asserted.
    start_run(32'd4);
    push_exp(32'd4, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(4, -1, -1, 1'b0, -1, fc);
    end_run("no_tlast");

    // 40 beats with backpressure; seed wraps FC->00 at beat 31.
    start_run(32'd40);
    push_exp(32'd40, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send(40, 39, -1, 1'b1, -1, fc);
    end_run("stall");

    // Zero-length run.
    start_run(32'd0);
    push_exp(32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("size0_done", 32'(ap_done), 32'd1);
    check("size0_tready", 32'(tready), 32'd0);
    @(negedge clk);
    #1;
    check("size0_pass_holds", 32'(pass), 32'd1);

    // Reset mid-run at beat 5 of 10, then a fresh 2-beat run.
    start_run(32'd10);
    send(10, 9, -1, 1'b0, 5, fc);
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    #1;
    check("rst_hold_tready", 32'(tready), 32'd0);
    reset_n = 1'b1;
    start_run(32'd2);
    push_exp(32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send(2, 1, -1, 1'b0, -1, fc);
    end_run("after_rst");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
